memoria_instrucoes_boot: RTL and testbench

Parametrised instruction memory with a boot-load channel and a handshaked fetch port for the ARM core. After reset it accepts a program image as a word stream into consecutive addresses, then switches to run mode. In run mode it serves byte-addressed PC fetches with one-cycle latency and flags misaligned PCs. A byte-enabled write port and a reload request allow the memory to be patched or fully reloaded while the core runs.

---
 rtl/memoria_instrucoes_boot.sv | 131 +++++++++++++
 tb/tb_memoria_instrucoes_boot.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_instrucoes_boot.sv
// rtl/memoria_instrucoes_boot.sv - boot-loadable instruction memory with handshaked fetch and byte-enabled patch port
module memoria_instrucoes_boot #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter bit BOOT_LOAD  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fetch_req,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0] fetch_addr,
    output logic                              fetch_ready,
    output logic                              fetch_valid,
    output logic [DATA_WIDTH-1:0]             fetch_data,
    output logic                              fetch_misaligned,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH/8-1:0]           wr_be,
    input  logic                              load_valid,
    input  logic [DATA_WIDTH-1:0]             load_data,
    input  logic                              load_last,
    output logic                              load_ready,
    output logic [ADDR_WIDTH:0]               load_count,
    input  logic                              reload
);
    localparam int OFF = $clog2(DATA_WIDTH/8);
    localparam int NB  = DATA_WIDTH/8;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;
    localparam state_t RESET_ST = BOOT_LOAD ? ST_LOAD : ST_RUN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_misaligned_q, fetch_misaligned_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic                  load_accept;
    logic                  patch_we;
    logic [ADDR_WIDTH-1:0] fetch_word;
    logic [OFF-1:0]        fetch_off;
    logic [DATA_WIDTH-1:0] rd_word;

    assign load_accept = (state_q == ST_LOAD) && load_valid;
    assign patch_we    = (state_q == ST_RUN) && wr_en;
    assign fetch_word  = fetch_addr[ADDR_WIDTH+OFF-1:OFF];
    assign fetch_off   = fetch_addr[OFF-1:0];

    // Write-first read: bytes patched this cycle are forwarded into the fetch result
    always_comb begin
        rd_word = mem[fetch_word];
        for (int b = 0; b < NB; b++) begin
            if (patch_we && (wr_addr == fetch_word) && wr_be[b]) begin
                rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        load_count_d       = load_count_q;
        fetch_valid_d      = 1'b0;
        fetch_misaligned_d = 1'b0;
        fetch_data_d       = fetch_data_q;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    load_count_d = load_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    // The final address ends the load so the count can never wrap
                    if (load_last || (load_count_q[ADDR_WIDTH-1:0] == '1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    if (fetch_off != '0) begin
                        fetch_misaligned_d = 1'b1;
                        fetch_data_d       = '0;
                    end else begin
                        fetch_data_d = rd_word;
                    end
                end
                if (reload) begin
                    state_d      = ST_LOAD;
                    load_count_d = '0;
                end
            end
            default: state_d = RESET_ST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= RESET_ST;
            load_count_q       <= '0;
            fetch_valid_q      <= 1'b0;
            fetch_misaligned_q <= 1'b0;
            fetch_data_q       <= '0;
        end else begin
            state_q            <= state_d;
            load_count_q       <= load_count_d;
            fetch_valid_q      <= fetch_valid_d;
            fetch_misaligned_q <= fetch_misaligned_d;
            fetch_data_q       <= fetch_data_d;
        end
    end

    // Storage is deliberately outside reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem[load_count_q[ADDR_WIDTH-1:0]] <= load_data;
        end else if (patch_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign fetch_ready      = (state_q == ST_RUN);
    assign load_ready       = (state_q == ST_LOAD);
    assign fetch_valid      = fetch_valid_q;
    assign fetch_data       = fetch_data_q;
    assign fetch_misaligned = fetch_misaligned_q;
    assign load_count       = load_count_q;
endmodule

// File: tb/tb_memoria_instrucoes_boot.sv
// tb/tb_memoria_instrucoes_boot.sv - self-checking bench for memoria_instrucoes_boot
module tb_memoria_instrucoes_boot;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [13:0] fetch_addr = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_misaligned;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic [12:0] load_count;
    logic        reload = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [0:4095];
    int          count_m = 0;
    logic [31:0] img [$];

    always #5 clk = ~clk;

    memoria_instrucoes_boot #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BOOT_LOAD(1'b1)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_misaligned(fetch_misaligned),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count), .reload(reload)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_patch(input int a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic stream(input int n, input bit use_last, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 20000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                load_valid = 1'b0; load_last = 1'b0;
            end else begin
                load_valid = 1'b1; load_data = img[i]; load_last = use_last && (i == n - 1);
                checks++; if (load_ready !== 1'b1) begin $display("FAIL stream_load_ready got=%b exp=1 word=%0d", load_ready, i); failures++; end
            end
            tick(); cyc++;
            if (load_valid) begin mem_m[count_m % 4096] = img[i]; count_m++; i++; end
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++; if (i != n) begin $display("FAIL stream_timeout got=%0d exp=%0d", i, n); failures++; end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (fetch_valid !== 1'b0) begin $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); failures++; end
        checks++; if (fetch_data !== 32'h0) begin $display("FAIL rst_fetch_data got=%h exp=0", fetch_data); failures++; end
        checks++; if (fetch_misaligned !== 1'b0) begin $display("FAIL rst_misaligned got=%b exp=0", fetch_misaligned); failures++; end
        checks++; if (load_count !== 13'd0) begin $display("FAIL rst_load_count got=%0d exp=0", load_count); failures++; end
        checks++; if (load_ready !== 1'b1 || fetch_ready !== 1'b0) begin $display("FAIL rst_state got=%b%b exp=10", load_ready, fetch_ready); failures++; end
        rst = 1'b0;
        count_m = 0;
    endtask

    task automatic test_boot();
        img = {};
        img.push_back(32'h11111111); img.push_back(32'h22222222); img.push_back(32'h33333333);
        stream(3, 1'b1, 1'b0);
        checks++; if (load_count !== 13'(count_m)) begin $display("FAIL boot_count got=%0d exp=%0d", load_count, count_m); failures++; end
        checks++; if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin $display("FAIL boot_run got=%b%b exp=10", fetch_ready, load_ready); failures++; end
        fetch_req = 1'b1; fetch_addr = 14'h008;
        tick();
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_misaligned !== 1'b0) begin $display("FAIL boot_fetch_flags got=%b%b exp=10", fetch_valid, fetch_misaligned); failures++; end
        checks++; if (fetch_data !== mem_m[2]) begin $display("FAIL boot_fetch_data got=%h exp=%h", fetch_data, mem_m[2]); failures++; end
    endtask

    task automatic test_misaligned();
        fetch_req = 1'b1; fetch_addr = 14'h006;
        tick();
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_misaligned !== 1'b1 || fetch_data !== 32'h0) begin
            $display("FAIL misaligned got=%b%b %h exp=11 0", fetch_valid, fetch_misaligned, fetch_data); failures++; end
        tick();
        checks++; if (fetch_valid !== 1'b0 || fetch_misaligned !== 1'b0 || fetch_data !== 32'h0) begin
            $display("FAIL idle_hold got=%b%b %h exp=00 0", fetch_valid, fetch_misaligned, fetch_data); failures++; end
        fetch_req = 1'b1; fetch_addr = 14'h004;
        tick();
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || fetch_misaligned !== 1'b0 || fetch_data !== mem_m[1]) begin
            $display("FAIL aligned_after_mis got=%b%b %h exp=10 %h", fetch_valid, fetch_misaligned, fetch_data, mem_m[1]); failures++; end
    endtask

    task automatic test_patch();
        logic [31:0] exp;
        wr_en = 1'b1; wr_addr = 12'd1; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        fetch_req = 1'b1; fetch_addr = 14'h004;
        model_patch(1, 4'b0101, 32'hAABBCCDD);
        tick();
        wr_en = 1'b0;
        checks++; if (fetch_data !== mem_m[1]) begin $display("FAIL patch_forward got=%h exp=%h", fetch_data, mem_m[1]); failures++; end
        tick();
        checks++; if (fetch_data !== mem_m[1]) begin $display("FAIL patch_persist got=%h exp=%h", fetch_data, mem_m[1]); failures++; end
        for (int k = 0; k < 24; k++) begin
            int wa;
            int fw;
            int off;
            wa = $urandom_range(0, 2); fw = $urandom_range(0, 2);
            off = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            wr_en = 1'b1; wr_addr = 12'(wa); wr_data = $urandom; wr_be = 4'($urandom_range(0, 15));
            fetch_req = 1'b1; fetch_addr = 14'(fw * 4 + off);
            model_patch(wa, wr_be, wr_data);
            exp = (off != 0) ? 32'h0 : mem_m[fw];
            tick();
            checks++; if (fetch_valid !== 1'b1 || fetch_misaligned !== (off != 0) || fetch_data !== exp) begin
                $display("FAIL patch_rand%0d got=%b%b %h exp=1%b %h", k, fetch_valid, fetch_misaligned, fetch_data, off != 0, exp); failures++; end
        end
        wr_en = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp = '0;
        fetch_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            int a;
            a = $urandom_range(0, 11);
            fetch_addr = 14'(a);
            exp = (a % 4 != 0) ? 32'h0 : mem_m[a / 4];
            tick();
            checks++; if (fetch_valid !== 1'b1 || fetch_misaligned !== (a % 4 != 0) || fetch_data !== exp) begin
                $display("FAIL b2b%0d got=%b%b %h exp=1%b %h", k, fetch_valid, fetch_misaligned, fetch_data, a % 4 != 0, exp); failures++; end
        end
        fetch_req = 1'b0;
        tick();
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== exp) begin $display("FAIL b2b_hold got=%b %h exp=0 %h", fetch_valid, fetch_data, exp); failures++; end
    endtask

    task automatic test_reload();
        logic [31:0] pd;
        pd = $urandom;
        reload = 1'b1; fetch_req = 1'b1; fetch_addr = 14'h004;
        wr_en = 1'b1; wr_addr = 12'd2; wr_data = pd; wr_be = 4'hF;
        model_patch(2, 4'hF, pd);
        tick();
        reload = 1'b0; count_m = 0;
        fetch_addr = 14'h000; wr_addr = 12'd0; wr_data = 32'hDEADBEEF;
        checks++; if (fetch_valid !== 1'b1 || fetch_data !== mem_m[1]) begin $display("FAIL reload_fetch got=%b %h exp=1 %h", fetch_valid, fetch_data, mem_m[1]); failures++; end
        checks++; if (load_ready !== 1'b1 || fetch_ready !== 1'b0 || load_count !== 13'd0) begin
            $display("FAIL reload_state got=%b%b %0d exp=10 0", load_ready, fetch_ready, load_count); failures++; end
        tick();
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== mem_m[1]) begin $display("FAIL load_ignores_fetch got=%b %h exp=0 %h", fetch_valid, fetch_data, mem_m[1]); failures++; end
        fetch_req = 1'b0; wr_en = 1'b0;
        img = {};
        img.push_back($urandom); img.push_back($urandom);
        stream(2, 1'b1, 1'b1);
        checks++; if (load_count !== 13'(count_m) || fetch_ready !== 1'b1) begin $display("FAIL reload_done got=%0d %b exp=%0d 1", load_count, fetch_ready, count_m); failures++; end
        for (int w = 0; w < 3; w++) begin
            fetch_req = 1'b1; fetch_addr = 14'(w * 4);
            tick();
            checks++; if (fetch_data !== mem_m[w]) begin $display("FAIL reload_word%0d got=%h exp=%h", w, fetch_data, mem_m[w]); failures++; end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_midload();
        reload = 1'b1;
        tick();
        reload = 1'b0; count_m = 0;
        img = {};
        for (int i = 0; i < 5; i++) img.push_back($urandom);
        stream(2, 1'b0, 1'b0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++; if (load_count !== 13'd2 || load_ready !== 1'b1) begin $display("FAIL reload_in_load got=%0d %b exp=2 1", load_count, load_ready); failures++; end
        rst = 1'b1;
        #1;
        checks++; if (load_count !== 13'd0 || load_ready !== 1'b1 || fetch_ready !== 1'b0) begin
            $display("FAIL midload_rst_state got=%0d %b%b exp=0 10", load_count, load_ready, fetch_ready); failures++; end
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0 || fetch_misaligned !== 1'b0) begin
            $display("FAIL midload_rst_outputs got=%b %h %b exp=0 0 0", fetch_valid, fetch_data, fetch_misaligned); failures++; end
        tick();
        rst = 1'b0; count_m = 0;
        img = {};
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        stream(3, 1'b1, 1'b1);
        for (int w = 0; w < 3; w++) begin
            fetch_req = 1'b1; fetch_addr = 14'(w * 4);
            tick();
            checks++; if (fetch_data !== mem_m[w]) begin $display("FAIL midload_word%0d got=%h exp=%h", w, fetch_data, mem_m[w]); failures++; end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_full_load();
        reload = 1'b1;
        tick();
        reload = 1'b0; count_m = 0;
        img = {};
        for (int i = 0; i < 4096; i++) img.push_back($urandom);
        stream(4096, 1'b0, 1'b1);
        checks++; if (load_count !== 13'(count_m) || count_m != 4096) begin $display("FAIL full_count got=%0d exp=%0d", load_count, count_m); failures++; end
        checks++; if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin $display("FAIL full_run got=%b%b exp=10", fetch_ready, load_ready); failures++; end
        fetch_req = 1'b1; fetch_addr = 14'h0000;
        tick();
        checks++; if (fetch_data !== img[0]) begin $display("FAIL full_word0 got=%h exp=%h", fetch_data, img[0]); failures++; end
        fetch_addr = 14'h3FFC;
        tick();
        checks++; if (fetch_data !== mem_m[4095]) begin $display("FAIL full_word4095 got=%h exp=%h", fetch_data, mem_m[4095]); failures++; end
        fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_boot();
        test_misaligned();
        test_patch();
        test_back_to_back();
        test_reload();
        test_reset_midload();
        test_full_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
